// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
// Round-robin front end that shares one sequential signed multiplier among
// NREQ requesters. Only one operation is in flight at a time.
//   clk, rst (async, active-low)
//   req_valid/req_a/req_b/req_ready    : per-requester operand handshake
//   rsp_valid/rsp_ready/rsp_result/rsp_err : per-requester response handshake
//   mul_start/mul_multiplicand/mul_multiplier/mul_result/mul_done : multiplier core
//   busy, grant_id                     : status
module booth_mul_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*WIDTH-1:0]      req_a,
  input  logic [NREQ*WIDTH-1:0]      req_b,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [2*WIDTH-1:0]         rsp_result,
  output logic                       rsp_err,
  output logic                       mul_start,
  output logic [WIDTH-1:0]           mul_multiplicand,
  output logic [WIDTH-1:0]           mul_multiplier,
  input  logic [2*WIDTH-1:0]         mul_result,
  input  logic                       mul_done,
  output logic                       busy,
  output logic [$clog2(NREQ)-1:0]    grant_id
);

  localparam int unsigned GW = $clog2(NREQ);
  localparam int unsigned IW = GW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               err_q, err_d;
  logic [TW-1:0]      wd_q, wd_d;

  logic [GW-1:0]      pick;
  logic               pick_vld;
  logic [IW-1:0]      idx;
  logic [WIDTH-1:0]   sel_a, sel_b;

  // Cyclic search starting at rr_ptr; wrap by subtraction instead of modulo.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = {1'b0, rr_ptr_q} + IW'(i);
      if (idx >= IW'(NREQ)) idx = idx - IW'(NREQ);
      if (!pick_vld && req_valid[idx[GW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick == GW'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    err_d     = err_q;
    wd_d      = wd_q;
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          req_ready[pick] = rst;
          grant_d         = pick;
          a_d             = sel_a;
          b_d             = sel_b;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_start = 1'b1;
        wd_d      = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          res_d   = mul_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wd_q == TW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (rsp_ready[grant_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign grant_id         = grant_q;
  assign mul_multiplicand = a_q;
  assign mul_multiplier   = b_q;
  assign rsp_result       = res_q;
  assign rsp_err          = err_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
module tb_booth_mul_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int TO = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_a, req_b;
  logic [NR-1:0]   req_ready, rsp_valid, rsp_ready;
  logic [2*W-1:0]  rsp_result;
  logic            rsp_err, mul_start;
  logic [W-1:0]    mul_multiplicand, mul_multiplier;
  logic [2*W-1:0]  mul_result;
  logic            mul_done, busy;
  logic [1:0]      grant_id;

  int vectors     = 0;
  int miscompares = 0;
  int ref_rr      = 0;

  // multiplier stub controls
  int  stub_lat = 1;
  bit  stub_en  = 1'b1;
  bit  stray    = 1'b0;
  int  pend     = 0;
  logic signed [31:0] pa, pb, prod;

  booth_mul_arbiter #(.NREQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_result(mul_result), .mul_done(mul_done), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: done pulses stub_lat cycles after start.
  initial begin
    mul_done   = 1'b0;
    mul_result = '0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (!rst) begin
        pend = 0;
      end else begin
        if (stray) begin
          mul_done = 1'b1;
          stray    = 1'b0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            mul_done   = 1'b1;
            mul_result = prod;
          end
        end
        if (mul_start && stub_en) begin
          pa   = $signed(mul_multiplicand);
          pb   = $signed(mul_multiplier);
          prod = pa * pb;
          pend = stub_lat;
        end
      end
    end
  end

  // Reference arbitration: first valid requester at or after ref_rr, cyclically.
  function automatic int ref_pick(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++)
      if (v[(ref_rr + k) % NR]) return (ref_rr + k) % NR;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    ref_rr = 0;
  endtask

  // One full operation for whichever requester the reference picks.
  task automatic serve(input int lat, input int hold, input bit drop);
    int eg, t, exp_t;
    logic [15:0] ea, eb;
    logic signed [31:0] ea32, eb32, ep;
    logic eerr;
    logic [NR-1:0] oh, noise;
    eg = ref_pick(req_valid);
    if (eg < 0) return;
    ea       = req_a[eg*W +: W];
    eb       = req_b[eg*W +: W];
    ea32     = $signed(ea);
    eb32     = $signed(eb);
    eerr     = !stub_en;
    ep       = eerr ? 32'sd0 : ea32 * eb32;
    oh       = '0;
    oh[eg]   = 1'b1;
    stub_lat = lat;
    exp_t    = stub_en ? lat + 1 : TO + 1;

    #1;
    t = 0;
    while (req_ready == '0 && t < 50) begin
      @(negedge clk); #1; t++;
    end
    vectors++;
    if (req_ready !== oh) begin
      miscompares++;
      $display("FAIL accept: req_ready=%b required %b", req_ready, oh);
    end

    @(negedge clk);
    if (drop) req_valid[eg] = 1'b0;
    #1;
    vectors++;
    if ({mul_start, mul_multiplicand, mul_multiplier, grant_id, busy, req_ready} !==
        {1'b1, ea, eb, 2'(eg), 1'b1, 4'b0}) begin
      miscompares++;
      $display("FAIL issue: start=%b a=%h b=%h gid=%0d busy=%b rdy=%b required 1 %h %h %0d 1 0000",
               mul_start, mul_multiplicand, mul_multiplier, grant_id, busy, req_ready, ea, eb, eg);
    end

    t = 0;
    while (rsp_valid == '0 && t < TO + 20) begin
      @(negedge clk); #1; t++;
    end
    vectors++;
    if (t != exp_t) begin
      miscompares++;
      $display("FAIL latency: rsp after %0d cycles required %0d", t, exp_t);
    end
    vectors++;
    if ({rsp_valid, rsp_result, rsp_err} !== {oh, ep, eerr}) begin
      miscompares++;
      $display("FAIL response: valid=%b result=%0d err=%b required %b %0d %b",
               rsp_valid, $signed(rsp_result), rsp_err, oh, ep, eerr);
    end

    for (int h = 0; h < hold; h++) begin
      noise     = NR'($urandom);
      noise[eg] = 1'b0;
      rsp_ready = noise;
      @(negedge clk); #1;
      vectors++;
      if ({rsp_valid, rsp_result, rsp_err, req_ready} !== {oh, ep, eerr, 4'b0}) begin
        miscompares++;
        $display("FAIL hold: valid=%b result=%0d err=%b rdy=%b required %b %0d %b 0000",
                 rsp_valid, $signed(rsp_result), rsp_err, req_ready, oh, ep, eerr);
      end
    end

    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    ref_rr = (eg + 1) % NR;
    t      = ref_pick(req_valid);
    oh     = '0;
    if (t >= 0) oh[t] = 1'b1;
    vectors++;
    if ({rsp_valid, busy, req_ready} !== {4'b0, 1'b0, oh}) begin
      miscompares++;
      $display("FAIL release: valid=%b busy=%b rdy=%b required 0000 0 %b",
               rsp_valid, busy, req_ready, oh);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_result, rsp_err, mul_start, mul_multiplicand,
         mul_multiplier, busy, grant_id} !== '0) begin
      miscompares++;
      $display("FAIL reset: outputs rdy=%b val=%b res=%h err=%b st=%b a=%h b=%h busy=%b gid=%0d required all 0",
               req_ready, rsp_valid, rsp_result, rsp_err, mul_start, mul_multiplicand,
               mul_multiplier, busy, grant_id);
    end
    @(negedge clk);
    rst    = 1'b1;
    ref_rr = 0;
  endtask

  task automatic test_single();
    set_req(0, 16'd7, 16'd3);
    serve(3, 0, 1'b1);
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_req(1, -16'sd5, 16'sd4);
    set_req(2, -16'sd8, -16'sd6);
    serve(2, 0, 1'b1);
    serve(1, 1, 1'b1);
    // rr_ptr should now be 3: requester 3 wins over requester 0
    set_req(0, 16'd11, 16'd12);
    set_req(3, 16'd100, -16'sd3);
    serve(1, 0, 1'b1);
    serve(1, 0, 1'b1);
  endtask

  task automatic test_fairness();
    do_reset();
    set_req(0, 16'h8000, 16'd5);
    set_req(1, 16'hFFFF, 16'd32767);
    set_req(2, 16'($urandom), 16'($urandom));
    set_req(3, 16'($urandom), 16'($urandom));
    for (int n = 0; n < 5; n++) serve(1 + n, 0, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    set_req(ref_rr, 16'($urandom), 16'($urandom));
    serve(4, 10, 1'b1);
  endtask

  task automatic test_timeout();
    stub_en = 1'b0;
    set_req(2, 16'd9, 16'd9);
    serve(1, 2, 1'b1);
    stub_en = 1'b1;
    stray   = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); #1;
      vectors++;
      if ({busy, rsp_valid} !== 5'b0) begin
        miscompares++;
        $display("FAIL stray_done: busy=%b valid=%b required 0 0000", busy, rsp_valid);
      end
    end
    set_req(1, 16'd300, -16'sd7);
    serve(2, 0, 1'b1);
  endtask

  task automatic test_reset_wait();
    set_req(ref_rr, 16'd100, 16'd3);
    stub_lat = 10;
    #1;
    while (req_ready == '0) begin
      @(negedge clk); #1;
    end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_result, rsp_err, mul_start, mul_multiplicand,
         mul_multiplier, busy, grant_id} !== '0) begin
      miscompares++;
      $display("FAIL reset_wait: busy=%b a=%h b=%h gid=%0d required all outputs 0",
               busy, mul_multiplicand, mul_multiplier, grant_id);
    end
    @(negedge clk);
    rst    = 1'b1;
    ref_rr = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk); #1;
      vectors++;
      if ({busy, rsp_valid} !== 5'b0) begin
        miscompares++;
        $display("FAIL dropped: busy=%b valid=%b required 0 0000", busy, rsp_valid);
      end
    end
    set_req(0, 16'd15, 16'd0);
    serve(2, 0, 1'b1);
  endtask

  task automatic test_random();
    logic [NR-1:0] m;
    for (int n = 0; n < 20; n++) begin
      m = NR'($urandom_range(1, 15));
      req_valid = '0;
      for (int i = 0; i < NR; i++)
        if (m[i]) set_req(i, 16'($urandom), 16'($urandom));
      serve($urandom_range(1, 6), $urandom_range(0, 3), 1'b1);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_reset_wait();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
